// File: rtl/philv_sequencer.sv
// Multi-cycle control sequencer for the PhilosophyV core: FETCH/DECODE/EXECUTE/MEM/WRITEBACK.
// Moore outputs from registered state/class; ir_load, mdr_load and store pc_write are qualified by mem_ready.
module philv_sequencer #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [31:0]      instr,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_sel,
  output logic             ir_load,
  output logic             mdr_load,
  output logic             control_override,
  output logic             alu_src_immed,
  output logic             reg_write,
  output logic             wb_sel_mem,
  output logic             pc_write,
  output logic             halt,
  output logic [1:0]       halt_cause,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instr_retired
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_HALT   = 3'd6;

  localparam logic [1:0] C_OP    = 2'd0;
  localparam logic [1:0] C_OPIMM = 2'd1;
  localparam logic [1:0] C_LOAD  = 2'd2;
  localparam logic [1:0] C_STORE = 2'd3;

  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic [1:0]       class_q, class_d;
  logic [7:0]       wait_q, wait_d;
  logic [1:0]       cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic waiting;
  logic timeout;
  logic retire;
  logic unused_instr_bits;

  assign unused_instr_bits = ^instr[31:7];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      class_q <= C_OP;
      wait_q  <= '0;
      cause_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
      wait_q  <= wait_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
    end
  end

  // The N-th consecutive wait cycle sees wait_q == N-1, so timeout fires on WAIT_LAST.
  assign waiting = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;
  assign timeout = waiting && (wait_q == WAIT_LAST);

  always_comb begin
    state_d = state_q;
    class_d = class_q;
    wait_d  = waiting ? wait_q + 8'd1 : wait_q;
    cause_d = cause_q;
    cnt_d   = cnt_q;
    retire  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d = S_FETCH;
          wait_d  = '0;
        end
      end
      S_FETCH: begin
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_HALT;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        state_d = S_EXEC;
        case (instr[6:0])
          7'b0110011: class_d = C_OP;
          7'b0010011: class_d = C_OPIMM;
          7'b0000011: class_d = C_LOAD;
          7'b0100011: class_d = C_STORE;
          default: begin
            state_d = S_HALT;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_EXEC: begin
        if ((class_q == C_LOAD) || (class_q == C_STORE)) begin
          state_d = S_MEM;
          wait_d  = '0;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          if (class_q == C_STORE) retire = 1'b1;
          else                    state_d = S_WB;
        end else if (timeout) begin
          state_d = S_HALT;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_WB:   retire = 1'b1;
      S_HALT: state_d = S_HALT;
      default: begin
        state_d = S_HALT;
        cause_d = CAUSE_ILLEGAL;
      end
    endcase

    if (retire) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (run) begin
        state_d = S_FETCH;
        wait_d  = '0;
      end else begin
        state_d = S_IDLE;
      end
    end
  end

  always_comb begin
    mem_req          = 1'b0;
    mem_we           = 1'b0;
    mem_addr_sel     = 1'b0;
    ir_load          = 1'b0;
    mdr_load         = 1'b0;
    control_override = 1'b0;
    alu_src_immed    = 1'b0;
    reg_write        = 1'b0;
    wb_sel_mem       = 1'b0;
    pc_write         = 1'b0;
    halt             = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req          = 1'b1;
        control_override = 1'b1;
        ir_load          = mem_ready;
      end
      S_EXEC: begin
        case (class_q)
          C_OP:    ;
          C_OPIMM: alu_src_immed = 1'b1;
          default: begin
            control_override = 1'b1;
            alu_src_immed    = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        mem_req          = 1'b1;
        mem_addr_sel     = 1'b1;
        control_override = 1'b1;
        alu_src_immed    = 1'b1;
        mem_we           = (class_q == C_STORE);
        pc_write         = (class_q == C_STORE) && mem_ready;
        mdr_load         = (class_q != C_STORE) && mem_ready;
      end
      S_WB: begin
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        wb_sel_mem = (class_q == C_LOAD);
      end
      S_HALT: halt = 1'b1;
      default: ;
    endcase
  end

  assign halt_cause    = cause_q;
  assign state         = state_q;
  assign instr_retired = cnt_q;

endmodule
